pattern_drive_sequencer: RTL and testbench

// Next-generation pattern-buffer drive stage: sits between the buffers store and the
// pad drivers. Registers the pat-side field/buffer pointers, selects per-phase fields

---
 rtl/pat_pkg.sv | 43 ++++
 rtl/pwm_sync.sv | 22 ++
 rtl/pattern_drive_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_pattern_drive_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pat_pkg.sv
// Shared definitions for the pattern drive stage: phase encoding, buffer
// record field offsets (as functions of the tweak-lane count) and the
// safe-off drive levels.
package pat_pkg;

   typedef enum logic [1:0] {
      PH_OFF  = 2'd0,
      PH_DEAD = 2'd1,
      PH_HIGH = 2'd2,
      PH_LOW  = 2'd3
   } phase_e;

   // Fixed fields at the start of every buffer record
   localparam int F_PDRIVE = 0;
   localparam int F_NDRIVE = 1;
   localparam int F_PSENSE = 2;
   localparam int F_PDELAY = 3;

   // Safe-off gate levels: P gates are active-low, N gates active-high
   localparam logic SAFE_P_LEVEL = 1'b1;
   localparam logic SAFE_N_LEVEL = 1'b0;

   function automatic int f_ptweak(input int k);
      return 4 + k;
   endfunction

   function automatic int f_nsense(input int nt);
      return 4 + nt;
   endfunction

   function automatic int f_ndelay(input int nt);
      return 5 + nt;
   endfunction

   function automatic int f_ntweak(input int nt, input int k);
      return 6 + nt + k;
   endfunction

   function automatic int f_nfields(input int nt);
      return 2 + 2 * (2 + nt);
   endfunction

endpackage

// File: rtl/pwm_sync.sv
// Two-flop synchroniser bringing the asynchronous pwm pin into clk.
module pwm_sync (
   input  logic clk,
   input  logic rst,
   input  logic pwm,
   output logic pwm_s
);

   logic meta;

   // first flop may go metastable, second resolves it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta  <= 1'b0;
         pwm_s <= 1'b0;
      end else begin
         meta  <= pwm;
         pwm_s <= meta;
      end
   end

endmodule

// File: rtl/pattern_drive_sequencer.sv
// Pattern-buffer drive stage: registers the pat-side pointers, tracks pwm
// phase with programmable dead-time and drives P/N gates plus tweak lanes
// from the active buffer record. Gates fall back to safe-off when disabled.
module pattern_drive_sequencer
   import pat_pkg::*;
#(
   parameter  int BUF_WIDTH   = 8,
   parameter  int BUF_SIZE    = 22,
   parameter  int NO_BUFS     = 8,
   parameter  int NO_TWEAKS   = 8,
   parameter  int DEAD_CYCLES = 2,
   localparam int NFIELDS     = f_nfields(NO_TWEAKS),
   localparam int BSEL_W      = $clog2(NO_BUFS)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           enable,
   input  logic                           pwm,
   input  logic [NFIELDS*BUF_WIDTH-1:0]   cur_buf,
   input  logic [BUF_WIDTH-1:0]           field_byte,
   input  logic [2:0]                     bufp_in,
   input  logic [BUF_SIZE-1:0]            fieldp_in,
   input  logic [BUF_SIZE-1:0]            fieldwp_in,
   input  logic [BUF_WIDTH-1:0]           field_in_in,
   input  logic                           field_write_in,
   output logic [2:0]                     bufp,
   output logic [BUF_SIZE-1:0]            fieldp,
   output logic [BUF_SIZE-1:0]            fieldwp,
   output logic [BUF_WIDTH-1:0]           field_in,
   output logic                           field_write,
   output logic [BUF_WIDTH-1:0]           field_byte_out,
   output logic [BSEL_W-1:0]              buffer_select,
   output logic [1:0]                     phase,
   output logic [BUF_WIDTH-1:0]           p_drive,
   output logic [BUF_WIDTH-1:0]           n_drive,
   output logic [BUF_WIDTH-1:0]           tweak_delay,
   output logic [BUF_WIDTH-1:0]           tweak_sense,
   output logic [NO_TWEAKS*BUF_WIDTH-1:0] tweak_drive
);

   localparam logic [3:0]        DEAD_LOAD = 4'(DEAD_CYCLES);
   localparam logic [BSEL_W-1:0] BSEL_MAX  = BSEL_W'(NO_BUFS - 1);
   localparam int                TW        = NO_TWEAKS * BUF_WIDTH;

   logic                 pwm_s;
   logic                 pwm_prev;
   logic                 pwm_edge;
   phase_e               state_reg, state_next, live_phase;
   logic [3:0]           dcnt_reg, dcnt_next;
   logic [BUF_WIDTH-1:0] p_drive_next, n_drive_next, delay_next, sense_next;
   logic [TW-1:0]        tweak_next, p_tweaks, n_tweaks;

   pwm_sync u_pwm_sync (
      .clk   (clk),
      .rst   (rst),
      .pwm   (pwm),
      .pwm_s (pwm_s)
   );

   assign pwm_edge   = (pwm_s != pwm_prev);
   assign live_phase = pwm_s ? PH_HIGH : PH_LOW;
   assign phase      = state_reg;

   // gather the P-side and N-side tweak lanes out of the record
   for (genvar gi = 0; gi < NO_TWEAKS; gi++) begin : g_lane
      assign p_tweaks[gi*BUF_WIDTH +: BUF_WIDTH] =
         cur_buf[f_ptweak(gi)*BUF_WIDTH +: BUF_WIDTH];
      assign n_tweaks[gi*BUF_WIDTH +: BUF_WIDTH] =
         cur_buf[f_ntweak(NO_TWEAKS, gi)*BUF_WIDTH +: BUF_WIDTH];
   end

   // pat-side pass-through pipeline, independent of enable
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bufp           <= '0;
         fieldp         <= '0;
         fieldwp        <= '0;
         field_in       <= '0;
         field_write    <= 1'b0;
         field_byte_out <= '0;
      end else begin
         bufp           <= bufp_in;
         fieldp         <= fieldp_in;
         fieldwp        <= fieldwp_in;
         field_in       <= field_in_in;
         field_write    <= field_write_in;
         field_byte_out <= field_byte;
      end
   end

   // pwm history for edge detection and buffer settle counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_prev      <= 1'b0;
         buffer_select <= BSEL_MAX;
      end else begin
         pwm_prev <= pwm_s;
         if (pwm_edge)
            buffer_select <= '0;
         else if (buffer_select != BSEL_MAX)
            buffer_select <= buffer_select + 1'b1;
      end
   end

   // phase state machine: next state and dead-time counter
   always_comb begin
      state_next = state_reg;
      dcnt_next  = dcnt_reg;
      if (!enable) begin
         state_next = PH_OFF;
         dcnt_next  = '0;
      end else begin
         case (state_reg)
            PH_OFF: begin
               state_next = PH_DEAD;
               dcnt_next  = DEAD_LOAD;
            end
            PH_DEAD: begin
               if (pwm_edge) begin
                  // a fresh edge restarts the dead-time from full
                  if (DEAD_CYCLES == 0)
                     state_next = live_phase;
                  else
                     dcnt_next = DEAD_LOAD;
               end else if (dcnt_reg <= 4'd1) begin
                  state_next = pwm_prev ? PH_HIGH : PH_LOW;
                  dcnt_next  = '0;
               end else begin
                  dcnt_next = dcnt_reg - 4'd1;
               end
            end
            default: begin
               if (pwm_edge) begin
                  if (DEAD_CYCLES == 0) begin
                     state_next = live_phase;
                  end else begin
                     state_next = PH_DEAD;
                     dcnt_next  = DEAD_LOAD;
                  end
               end
            end
         endcase
      end
   end

   // drive values for the state being entered; fields re-read every cycle
   always_comb begin
      p_drive_next = {BUF_WIDTH{SAFE_P_LEVEL}};
      n_drive_next = {BUF_WIDTH{SAFE_N_LEVEL}};
      delay_next   = '0;
      sense_next   = '0;
      tweak_next   = '0;
      case (state_next)
         PH_HIGH: begin
            p_drive_next = cur_buf[F_PDRIVE*BUF_WIDTH +: BUF_WIDTH];
            sense_next   = cur_buf[F_PSENSE*BUF_WIDTH +: BUF_WIDTH];
            delay_next   = cur_buf[F_PDELAY*BUF_WIDTH +: BUF_WIDTH];
            tweak_next   = p_tweaks;
         end
         PH_LOW: begin
            n_drive_next = cur_buf[F_NDRIVE*BUF_WIDTH +: BUF_WIDTH];
            sense_next   = cur_buf[f_nsense(NO_TWEAKS)*BUF_WIDTH +: BUF_WIDTH];
            delay_next   = cur_buf[f_ndelay(NO_TWEAKS)*BUF_WIDTH +: BUF_WIDTH];
            tweak_next   = n_tweaks;
         end
         default: ;
      endcase
   end

   // state register and registered gate outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= PH_OFF;
         dcnt_reg    <= '0;
         p_drive     <= {BUF_WIDTH{SAFE_P_LEVEL}};
         n_drive     <= {BUF_WIDTH{SAFE_N_LEVEL}};
         tweak_delay <= '0;
         tweak_sense <= '0;
         tweak_drive <= '0;
      end else begin
         state_reg   <= state_next;
         dcnt_reg    <= dcnt_next;
         p_drive     <= p_drive_next;
         n_drive     <= n_drive_next;
         tweak_delay <= delay_next;
         tweak_sense <= sense_next;
         tweak_drive <= tweak_next;
      end
   end

endmodule

// File: tb/tb_pattern_drive_sequencer.sv
// Bench for pattern_drive_sequencer: directed pwm/enable/reset scenarios
// followed by a random stretch, all checked cycle by cycle against a
// timeline model (time since last OFF / last pwm edge) of the drive stage.
module tb_pattern_drive_sequencer;

   localparam int W   = 8;
   localparam int NH  = 1024;

   logic clk = 1'b0;
   logic rst, enable, pwm;
   logic [175:0] cur_buf;
   logic [111:0] cur_buf2;
   logic [7:0]   field_byte, field_in_in;
   logic [2:0]   bufp_in;
   logic [21:0]  fieldp_in, fieldwp_in;
   logic         field_write_in;

   logic [2:0]  bufp, bufp2;
   logic [21:0] fieldp, fieldwp, fieldp2, fieldwp2;
   logic [7:0]  field_in, field_byte_out, field_in2, field_byte_out2;
   logic        field_write, field_write2;
   logic [2:0]  buffer_select, buffer_select2;
   logic [1:0]  phase, phase2;
   logic [7:0]  p_drive, n_drive, tweak_delay, tweak_sense;
   logic [7:0]  p_drive2, n_drive2, tweak_delay2, tweak_sense2;
   logic [63:0] tweak_drive;
   logic [31:0] tweak_drive2;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // per-posedge history of what the DUT captured
   bit           rst_h [NH];
   bit           en_h  [NH];
   bit           pin_h [NH];
   logic [191:0] buf_h [NH];
   logic [191:0] buf2_h[NH];
   logic [63:0]  pat_h [NH];

   always #5 clk = ~clk;

   pattern_drive_sequencer dut (
      .clk(clk), .rst(rst), .enable(enable), .pwm(pwm), .cur_buf(cur_buf),
      .field_byte(field_byte), .bufp_in(bufp_in), .fieldp_in(fieldp_in),
      .fieldwp_in(fieldwp_in), .field_in_in(field_in_in),
      .field_write_in(field_write_in), .bufp(bufp), .fieldp(fieldp),
      .fieldwp(fieldwp), .field_in(field_in), .field_write(field_write),
      .field_byte_out(field_byte_out), .buffer_select(buffer_select),
      .phase(phase), .p_drive(p_drive), .n_drive(n_drive),
      .tweak_delay(tweak_delay), .tweak_sense(tweak_sense),
      .tweak_drive(tweak_drive)
   );

   pattern_drive_sequencer #(.NO_TWEAKS(4), .DEAD_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .enable(enable), .pwm(pwm), .cur_buf(cur_buf2),
      .field_byte(field_byte), .bufp_in(bufp_in), .fieldp_in(fieldp_in),
      .fieldwp_in(fieldwp_in), .field_in_in(field_in_in),
      .field_write_in(field_write_in), .bufp(bufp2), .fieldp(fieldp2),
      .fieldwp(fieldwp2), .field_in(field_in2), .field_write(field_write2),
      .field_byte_out(field_byte_out2), .buffer_select(buffer_select2),
      .phase(phase2), .p_drive(p_drive2), .n_drive(n_drive2),
      .tweak_delay(tweak_delay2), .tweak_sense(tweak_sense2),
      .tweak_drive(tweak_drive2)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp_v);
      end
   endtask

   function automatic logic [7:0] fld(input logic [191:0] b, input int f);
      return 8'(b >> (f * W));
   endfunction

   // the state machine acts on a pin change at posedge k when the
   // synchronised value (pin two edges back) differs from the one before
   function automatic bit edge_at(input int k);
      return !rst_h[k] && (pin_h[k-2] != pin_h[k-3]);
   endfunction

   // 0 OFF, 1 DEAD, 2 HIGH, 3 LOW after posedge m for dead-time d
   function automatic int exp_state(input int m, input int d);
      int a, s, len;
      if (rst_h[m] || !en_h[m]) return 0;
      a = m;
      while (!(rst_h[a] || !en_h[a])) a--;
      s   = a + 1;
      len = (d < 1) ? 1 : d;
      for (int k = a + 2; k <= m; k++)
         if (edge_at(k)) begin
            s   = k;
            len = d;
         end
      if (m < s + len) return 1;
      return pin_h[m-2] ? 2 : 3;
   endfunction

   function automatic int exp_bsel(input int m);
      int k;
      k = m;
      while (!rst_h[k] && !edge_at(k)) k--;
      if (rst_h[k]) return 7;
      return (m - k > 7) ? 7 : (m - k);
   endfunction

   task automatic check_cycle();
      int m, st, st2;
      logic [7:0]  ep, en_v, es, ed, ep2, en2, el3;
      logic [63:0] et;
      m  = cyc;
      st = exp_state(m, 2);
      ep = 8'hFF; en_v = 8'h00; es = 8'h00; ed = 8'h00; et = '0;
      if (st == 2) begin
         ep = fld(buf_h[m], 0);
         es = fld(buf_h[m], 2);
         ed = fld(buf_h[m], 3);
         for (int k = 0; k < 8; k++) et[k*W +: W] = fld(buf_h[m], 4 + k);
      end else if (st == 3) begin
         en_v = fld(buf_h[m], 1);
         es   = fld(buf_h[m], 4 + 8);
         ed   = fld(buf_h[m], 5 + 8);
         for (int k = 0; k < 8; k++) et[k*W +: W] = fld(buf_h[m], 6 + 8 + k);
      end
      chk("phase", 64'(phase), 64'(st));
      chk("p_drive", 64'(p_drive), 64'(ep));
      chk("n_drive", 64'(n_drive), 64'(en_v));
      chk("tweak_sense", 64'(tweak_sense), 64'(es));
      chk("tweak_delay", 64'(tweak_delay), 64'(ed));
      chk("tweak_drive", tweak_drive, et);
      chk("buffer_select", 64'(buffer_select), 64'(exp_bsel(m)));
      chk("pat_regs", {bufp, fieldp, fieldwp, field_in, field_write, field_byte_out},
          rst_h[m] ? 64'd0 : pat_h[m]);
      chk("p_n_exclusive", 64'(p_drive == 8'hFF || n_drive == 8'h00), 64'd1);

      st2 = exp_state(m, 0);
      ep2 = (st2 == 2) ? fld(buf2_h[m], 0) : 8'hFF;
      en2 = (st2 == 3) ? fld(buf2_h[m], 1) : 8'h00;
      el3 = (st2 == 2) ? fld(buf2_h[m], 7) : (st2 == 3) ? fld(buf2_h[m], 13) : 8'h00;
      chk("nd_phase", 64'(phase2), 64'(st2));
      chk("nd_p_drive", 64'(p_drive2), 64'(ep2));
      chk("nd_n_drive", 64'(n_drive2), 64'(en2));
      chk("nd_tweak_lane3", 64'(tweak_drive2[3*W +: W]), 64'(el3));
      $display("cyc=%0d rst=%0b en=%0b pwm=%0b phase=%0d p=%h n=%h bsel=%0d nd_phase=%0d",
               cyc, rst, enable, pwm, phase, p_drive, n_drive, buffer_select, phase2);
   endtask

   task automatic randomize_data();
      logic [191:0] r;
      for (int i = 0; i < 6; i++) r[i*32 +: 32] = $urandom;
      cur_buf = r[175:0];
      for (int i = 0; i < 6; i++) r[i*32 +: 32] = $urandom;
      cur_buf2       = r[111:0];
      field_byte     = 8'($urandom);
      field_in_in    = 8'($urandom);
      bufp_in        = 3'($urandom);
      fieldp_in      = 22'($urandom);
      fieldwp_in     = 22'($urandom);
      field_write_in = 1'($urandom);
   endtask

   // one clock: record what the edge captured, check, then new stimulus
   task automatic step();
      @(posedge clk);
      cyc++;
      if (cyc >= NH) begin
         $display("FAIL history cyc=%0d observed=overflow expected=below %0d", cyc, NH);
         $fatal(1, "history overflow");
      end
      rst_h[cyc]  = rst;
      en_h[cyc]   = rst ? 1'b0 : enable;
      pin_h[cyc]  = rst ? 1'b0 : pwm;
      buf_h[cyc]  = 192'(cur_buf);
      buf2_h[cyc] = 192'(cur_buf2);
      pat_h[cyc]  = {bufp_in, fieldp_in, fieldwp_in, field_in_in, field_write_in, field_byte};
      #1;
      check_cycle();
      randomize_data();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; pwm = 1'b0;
      randomize_data();
      rst_h[0] = 1'b1;
      run(4);

      // power-up: steady high pwm, two dead cycles then P drive
      rst = 1'b0; enable = 1'b1; pwm = 1'b1;
      run(12);
      // fall to low phase; settle counter runs up and holds
      pwm = 1'b0;
      run(13);
      // two edges one cycle apart: dead-time restarts
      pwm = 1'b1;
      run(1);
      pwm = 1'b0;
      run(10);
      // enable dropped while driving low
      enable = 1'b0;
      run(3);
      enable = 1'b1;
      run(8);
      // reset asserted while driving high
      pwm = 1'b1;
      run(10);
      rst = 1'b1;
      #1;
      chk("rst_async_phase", 64'(phase), 64'd0);
      chk("rst_async_p_drive", 64'(p_drive), 64'hFF);
      chk("rst_async_n_drive", 64'(n_drive), 64'h00);
      chk("rst_async_tweaks", tweak_drive, 64'd0);
      chk("rst_async_bsel", 64'(buffer_select), 64'd7);
      chk("rst_async_nd_phase", 64'(phase2), 64'd0);
      run(3);
      rst = 1'b0;
      run(8);
      // random pwm activity and occasional enable drops
      for (int i = 0; i < 250; i++) begin
         if ($urandom_range(0, 5) == 0) pwm = ~pwm;
         enable = ($urandom_range(0, 15) != 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
